reverb_pio_irq: RTL and testbench

Parametrised Avalon-MM slave general-purpose I/O port for the reverb system, the successor to the fixed 2-bit output-only PIO. Provides a WIDTH-bit output register with atomic set/clear access, a synchronised WIDTH-bit input port with per-bit edge capture, and a maskable level interrupt to the Nios II processor. Sits on the system interconnect next to the other memory-mapped peripherals; drives board control lines and samples external status lines.

---
 rtl/reverb_pio_irq.sv | 150 +++++++++++++++
 tb/tb_reverb_pio_irq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reverb_pio_irq.sv
// reverb_pio_irq
//   Avalon-MM slave GPIO port: WIDTH-bit output register with atomic
//   set/clear, synchronised WIDTH-bit input with sticky per-bit edge capture,
//   and a maskable level interrupt.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address (0..7)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data (bits above WIDTH-1 ignored)
//   readdata    combinational read data (bits above WIDTH-1 are 0)
//   in_port     asynchronous external inputs
//   out_port    output register contents
//   irq         level interrupt, |(EDGE_CAP & IRQ_MASK)
module reverb_pio_irq #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    A_DATA_OUT = 3'd0,
    A_DATA_IN  = 3'd1,
    A_IRQ_MASK = 3'd2,
    A_EDGE_CAP = 3'd3,
    A_OUTSET   = 3'd4,
    A_OUTCLR   = 3'd5,
    A_RSVD6    = 3'd6,
    A_RSVD7    = 3'd7
  } reg_addr_e;

  // Detection stays disabled until the counter reaches ARM_MAX, giving the
  // synchroniser and prev register time to fill with the real input levels.
  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

  reg_addr_e        w_addr;
  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_raw_edge;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_armed;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [ARM_W-1:0] r_arm;

  assign w_addr = reg_addr_e'(address);
  assign w_wr   = chipselect & ~write_n;
  assign w_wd   = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_wd_upper
      logic w_unused_wd;
      assign w_unused_wd = ^writedata[31:WIDTH];
    end
  endgenerate

  // Input synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // prev tracks sync unconditionally, including while the port is arming
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev <= '0;
    else          r_prev <= w_sync;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_arm <= '0;
    else if (r_arm != ARM_W'(ARM_MAX)) r_arm <= r_arm + 1'b1;
  end

  assign w_armed = (r_arm == ARM_W'(ARM_MAX));

  always_comb begin
    w_raw_edge = w_sync & ~r_prev;
    if (EDGE_TYPE == 1)      w_raw_edge = ~w_sync & r_prev;
    else if (EDGE_TYPE == 2) w_raw_edge = w_sync ^ r_prev;
  end

  assign w_edge = w_armed ? w_raw_edge : '0;
  assign w_clr  = (w_wr && (w_addr == A_EDGE_CAP)) ? w_wd : '0;

  // A new edge overrides a write-1-clear on the same bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cap <= '0;
    else          r_cap <= (r_cap & ~w_clr) | w_edge;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= OUT_RESET;
    end else if (w_wr) begin
      case (w_addr)
        A_DATA_OUT: r_out <= w_wd;
        A_OUTSET:   r_out <= r_out | w_wd;
        A_OUTCLR:   r_out <= r_out & ~w_wd;
        default:    r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              r_mask <= '0;
    else if (w_wr && (w_addr == A_IRQ_MASK))   r_mask <= w_wd;
  end

  always_comb begin
    readdata = '0;
    case (w_addr)
      A_DATA_OUT: readdata = 32'(r_out);
      A_DATA_IN:  readdata = 32'(w_sync);
      A_IRQ_MASK: readdata = 32'(r_mask);
      A_EDGE_CAP: readdata = 32'(r_cap);
      default:    readdata = '0;
    endcase
  end

  assign out_port = r_out;
  assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_reverb_pio_irq.sv
module tb_reverb_pio_irq;

  localparam int unsigned W   = 8;
  localparam logic [7:0]  ORS = 8'hA5;
  localparam int unsigned SS  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] in_port;
  logic [W-1:0] out_port;
  logic        irq;

  reverb_pio_irq #(
    .WIDTH(W), .OUT_RESET(ORS), .EDGE_TYPE(0), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic expect_read(input string tag, input logic [2:0] a, input logic [31:0] v);
    logic [31:0] d;
    sb_push(tag, v);
    bus_read(a, d);
    sb_check(d);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '1;

    // Reset with inputs already high
    repeat (2) @(negedge clk);
    sb_push("rst_out_port", 32'(ORS)); sb_check(32'(out_port));
    sb_push("rst_irq", 32'd0);         sb_check(32'(irq));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) expect_read("no_false_edge", 3'd3, 32'h0);
    expect_read("data_in_ff", 3'd1, 32'hFF);
    expect_read("mask_rst", 3'd2, 32'h0);
    expect_read("data_out_rst", 3'd0, 32'hA5);

    // Output register: load, set, clear
    sb_push("out_load", 32'h0F); bus_write(3'd0, 32'hFFFF_FF0F); sb_check(32'(out_port));
    sb_push("out_set", 32'h3F);  bus_write(3'd4, 32'h30);        sb_check(32'(out_port));
    sb_push("out_clr", 32'h3C);  bus_write(3'd5, 32'h03);        sb_check(32'(out_port));
    expect_read("rd_outset", 3'd4, 32'h0);
    expect_read("rd_outclr", 3'd5, 32'h0);
    bus_write(3'd6, 32'hFF);
    expect_read("rsvd_wr_ignored", 3'd0, 32'h3C);
    expect_read("rd_rsvd7", 3'd7, 32'h0);

    // Rising-edge capture latency
    in_port = '0;
    cycles(5);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h01);
    expect_read("cap_clean", 3'd3, 32'h0);
    @(negedge clk);
    in_port[0] = 1'b1;
    sb_push("irq_not_yet", 32'd0);
    repeat (SS) @(posedge clk);
    #1;
    sb_check(32'(irq));
    sb_push("irq_latency", 32'd1);
    @(posedge clk);
    #1;
    sb_check(32'(irq));
    expect_read("cap_bit0", 3'd3, 32'h01);
    expect_read("data_in_bit0", 3'd1, 32'h01);
    in_port[0] = 1'b0;
    cycles(5);
    expect_read("fall_ignored", 3'd3, 32'h01);

    // Edge and write-1-clear in the same cycle: edge wins
    @(negedge clk);
    in_port[0] = 1'b1;
    repeat (SS) @(posedge clk);
    bus_write(3'd3, 32'h01);
    sb_push("edge_wins_irq", 32'd1); sb_check(32'(irq));
    expect_read("edge_wins_cap", 3'd3, 32'h01);
    bus_write(3'd3, 32'h01);
    sb_push("clear_irq", 32'd0); sb_check(32'(irq));
    expect_read("clear_cap", 3'd3, 32'h00);

    // Masking
    in_port = 8'h09;
    cycles(5);
    sb_push("mask_other_bit", 32'd0); sb_check(32'(irq));
    bus_write(3'd2, 32'h00);
    sb_push("mask_zero_irq", 32'd0); sb_check(32'(irq));
    expect_read("cap_bit3", 3'd3, 32'h08);
    bus_write(3'd2, 32'h08);
    sb_push("mask_bit3_irq", 32'd1); sb_check(32'(irq));
    expect_read("mask_rd", 3'd2, 32'h08);

    // Mid-run asynchronous reset
    in_port = 8'h00;
    cycles(5);
    in_port = 8'hFF;
    cycles(5);
    bus_write(3'd0, 32'h55);
    bus_write(3'd2, 32'hFF);
    expect_read("cap_all", 3'd3, 32'hFF);
    sb_push("out_55", 32'h55);   sb_check(32'(out_port));
    sb_push("irq_all", 32'd1);   sb_check(32'(irq));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    address = 3'd3;
    #1;
    sb_push("async_out", 32'(ORS)); sb_check(32'(out_port));
    sb_push("async_irq", 32'd0);    sb_check(32'(irq));
    sb_push("async_cap", 32'd0);    sb_check(readdata);
    address = 3'd2;
    #1;
    sb_push("async_mask", 32'd0);   sb_check(readdata);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(12);
    expect_read("rearm_no_false", 3'd3, 32'h0);
    bus_write(3'd2, 32'hFF);
    in_port = 8'h00;
    cycles(5);
    in_port = 8'hF0;
    cycles(5);
    expect_read("rearm_capture", 3'd3, 32'hF0);
    sb_push("rearm_irq", 32'd1); sb_check(32'(irq));

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
